// File: rtl/wdec_frame.sv
// -----------------------------------------------------------------------------
// wdec_frame -- block-sum word decoder
//
// Consumes the encoder's byte stream (four bytes per word, MSB first:
// left[15:8], left[7:0], right[15:8], right[7:0]), rebuilds the left and
// right 16-bit block sums and, one cycle later, publishes their signed
// difference, their sum, a balance verdict and the row-block index.
// A partial word that stalls for GAP_MAX idle cycles is dropped and flagged.
//
// Optional feature macro: WDEC_PEAK_EN (per-frame max |diff| on `peak`).
//
// Ports:
//   dclk        in   clock, all logic on the rising edge
//   rst_n       in   asynchronous active-low reset
//   sof         in   start-of-frame pulse (highest priority)
//   ready       in   din holds a valid byte this cycle
//   din[7:0]    in   byte stream
//   left[15:0]  out  reassembled left sum
//   right[15:0] out  reassembled right sum
//   diff[16:0]  out  left - right, two's complement
//   total[16:0] out  left + right
//   side[1:0]   out  00 balanced, 01 left heavier, 10 right heavier
//   blk_idx[3:0]out  row-block index of the current result
//   valid       out  one-cycle pulse, result outputs are new
//   frame_done  out  pulses with valid of the last row block
//   err         out  sticky: a partial word was discarded
//   peak[15:0]  out  max |diff| in frame (0 unless WDEC_PEAK_EN)
// -----------------------------------------------------------------------------
module wdec_frame #(
  parameter int ROW_BLOCKS = 2,
  parameter int THRESH     = 4,
  parameter int GAP_MAX    = 8
) (
  input  logic        dclk,
  input  logic        rst_n,
  input  logic        sof,
  input  logic        ready,
  input  logic [7:0]  din,
  output logic [15:0] left,
  output logic [15:0] right,
  output logic [16:0] diff,
  output logic [16:0] total,
  output logic [1:0]  side,
  output logic [3:0]  blk_idx,
  output logic        valid,
  output logic        frame_done,
  output logic        err,
  output logic [15:0] peak
);

  localparam int GW = $clog2(GAP_MAX + 1);

  typedef enum logic [2:0] {
    S_B0   = 3'd0,
    S_B1   = 3'd1,
    S_B2   = 3'd2,
    S_B3   = 3'd3,
    S_CALC = 3'd4
  } state_t;

  state_t        state_q;
  logic [23:0]   shift_q;
  logic [15:0]   left_q, right_q;
  logic [16:0]   diff_q, total_q;
  logic [1:0]    side_q;
  logic [3:0]    blk_idx_q, blk_cnt_q;
  logic          valid_q, frame_done_q, err_q;
  logic [GW-1:0] gap_q;

  // Arithmetic on the captured word, registered during CALC.
  logic [16:0] diff_d, total_d, abs_d;
  logic [1:0]  side_d;

  always_comb begin
    diff_d  = {1'b0, left_q} - {1'b0, right_q};
    total_d = {1'b0, left_q} + {1'b0, right_q};
    // |diff| never exceeds 65535, so 17 bits are ample and the top bit is 0.
    abs_d   = diff_d[16] ? (~diff_d + 17'd1) : diff_d;
    if (abs_d <= 17'(THRESH)) begin
      side_d = 2'b00;
    end else if (!diff_d[16]) begin
      side_d = 2'b01;
    end else begin
      side_d = 2'b10;
    end
  end

`ifdef WDEC_PEAK_EN
  logic [15:0] peak_q;
`endif

  always_ff @(posedge dclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_B0;
      shift_q      <= '0;
      left_q       <= '0;
      right_q      <= '0;
      diff_q       <= '0;
      total_q      <= '0;
      side_q       <= 2'b00;
      blk_idx_q    <= '0;
      blk_cnt_q    <= '0;
      valid_q      <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      gap_q        <= '0;
`ifdef WDEC_PEAK_EN
      peak_q       <= '0;
`endif
    end else begin
      valid_q      <= 1'b0;
      frame_done_q <= 1'b0;

      // Result stage: runs in CALC even when sof arrives, so an in-flight
      // word still reports with the block index it was captured under.
      if (state_q == S_CALC) begin
        diff_q    <= diff_d;
        total_q   <= total_d;
        side_q    <= side_d;
        valid_q   <= 1'b1;
        blk_idx_q <= blk_cnt_q;
        if (blk_cnt_q == 4'(ROW_BLOCKS - 1)) begin
          blk_cnt_q    <= '0;
          frame_done_q <= 1'b1;
        end else begin
          blk_cnt_q <= blk_cnt_q + 4'd1;
        end
`ifdef WDEC_PEAK_EN
        // Block 0 starts a new frame: load rather than compare.
        if (blk_cnt_q == 4'd0 || abs_d[15:0] > peak_q) begin
          peak_q <= abs_d[15:0];
        end
`endif
      end

      // Capture FSM. sof is evaluated last so its clears override the
      // counter/peak updates above.
      if (sof) begin
        blk_cnt_q <= '0;
        gap_q     <= '0;
        err_q     <= 1'b0;
`ifdef WDEC_PEAK_EN
        peak_q    <= '0;
`endif
        if (ready) begin
          shift_q <= {shift_q[15:0], din};
          state_q <= S_B1;
        end else begin
          state_q <= S_B0;
        end
      end else begin
        case (state_q)
          S_B0, S_CALC: begin
            // A byte during CALC is the first byte of the next word.
            gap_q <= '0;
            if (ready) begin
              shift_q <= {shift_q[15:0], din};
              state_q <= S_B1;
            end else begin
              state_q <= S_B0;
            end
          end
          S_B1, S_B2, S_B3: begin
            if (ready) begin
              gap_q <= '0;
              if (state_q == S_B3) begin
                left_q  <= shift_q[23:8];
                right_q <= {shift_q[7:0], din};
                state_q <= S_CALC;
              end else begin
                shift_q <= {shift_q[15:0], din};
                state_q <= (state_q == S_B1) ? S_B2 : S_B3;
              end
            end else if (gap_q == GW'(GAP_MAX - 1)) begin
              // Stall limit reached: drop the partial word.
              gap_q   <= '0;
              err_q   <= 1'b1;
              state_q <= S_B0;
            end else begin
              gap_q <= gap_q + GW'(1);
            end
          end
          default: begin
            state_q <= S_B0;
            gap_q   <= '0;
          end
        endcase
      end
    end
  end

  assign left       = left_q;
  assign right      = right_q;
  assign diff       = diff_q;
  assign total      = total_q;
  assign side       = side_q;
  assign blk_idx    = blk_idx_q;
  assign valid      = valid_q;
  assign frame_done = frame_done_q;
  assign err        = err_q;
`ifdef WDEC_PEAK_EN
  assign peak       = peak_q;
`else
  assign peak       = '0;
`endif

endmodule

// File: tb/tb_wdec_frame.sv
module tb_wdec_frame;

  logic        dclk = 1'b0;
  logic        rst_n;
  logic        sof;
  logic        ready;
  logic [7:0]  din;
  logic [15:0] left, right, peak;
  logic [16:0] diff, total;
  logic [1:0]  side;
  logic [3:0]  blk_idx;
  logic        valid, frame_done, err;

`ifdef WDEC_PEAK_EN
  localparam bit PK = 1'b1;
`else
  localparam bit PK = 1'b0;
`endif

  wdec_frame #(.ROW_BLOCKS(2), .THRESH(4), .GAP_MAX(8)) dut (
    .dclk(dclk), .rst_n(rst_n), .sof(sof), .ready(ready), .din(din),
    .left(left), .right(right), .diff(diff), .total(total), .side(side),
    .blk_idx(blk_idx), .valid(valid), .frame_done(frame_done), .err(err),
    .peak(peak)
  );

  always #5 dclk = ~dclk;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [16:0] diff;
    logic [16:0] total;
    logic [1:0]  side;
    logic [3:0]  blk;
    logic        fd;
    logic [15:0] peak;
    int          cyc;
  } res_t;

  res_t res_q[$];
  int   cyc    = 0;
  int   vcount = 0;

  always @(posedge dclk) cyc++;

  always @(negedge dclk) begin
    if (valid === 1'b1) begin
      res_q.push_back('{diff, total, side, blk_idx, frame_done, peak, cyc});
      vcount++;
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge dclk);
    ready = 1'b1;
    din   = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge dclk);
      ready = 1'b0;
    end
  endtask

  task automatic send_word(input logic [7:0] b0, b1, b2, b3);
    send(b0); send(b1); send(b2); send(b3);
  endtask

  // Waits (bounded) for the next captured result and compares every field.
  task automatic expect_res(input string tag, input logic [16:0] e_diff, input logic [16:0] e_total,
                            input logic [1:0] e_side, input logic [3:0] e_blk, input logic e_fd,
                            input logic [15:0] e_peak, output int got_cyc);
    res_t r;
    got_cyc = -1;
    for (int i = 0; i < 12 && res_q.size() == 0; i++) begin
      @(negedge dclk);
      #1;
    end
    if (res_q.size() == 0) begin
      check_val({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      r = res_q.pop_front();
      got_cyc = r.cyc;
      $display("result %s: diff=%h total=%0d side=%b blk=%0d fd=%b peak=%0d", tag, r.diff, r.total, r.side, r.blk, r.fd, r.peak);
      check_val({tag, "_diff"},  32'(r.diff),  32'(e_diff));
      check_val({tag, "_total"}, 32'(r.total), 32'(e_total));
      check_val({tag, "_side"},  32'(r.side),  32'(e_side));
      check_val({tag, "_blk"},   32'(r.blk),   32'(e_blk));
      check_val({tag, "_fd"},    32'(r.fd),    32'(e_fd));
      check_val({tag, "_peak"},  32'(r.peak),  PK ? 32'(e_peak) : 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1, vbase;
    rst_n = 1'b0; sof = 1'b0; ready = 1'b0; din = 8'h00;

    // Reset state
    idle(3);
    check_val("rst_left",  32'(left),  32'd0);
    check_val("rst_diff",  32'(diff),  32'd0);
    check_val("rst_side",  32'(side),  32'd0);
    check_val("rst_valid", 32'(valid), 32'd0);
    check_val("rst_err",   32'(err),   32'd0);
    check_val("rst_peak",  32'(peak),  32'd0);
    @(negedge dclk);
    rst_n = 1'b1;

    // T1: single word, exact latency
    send_word(8'h00, 8'h1B, 8'h00, 8'h36);
    idle(1);
    check_val("t1_left",   32'(left),  32'h001B);
    check_val("t1_right",  32'(right), 32'h0036);
    check_val("t1_valid_early", 32'(valid), 32'd0);
    idle(1);
    check_val("t1_valid",  32'(valid), 32'd1);
    check_val("t1_diff",   32'(diff),  32'h1FFE5);
    check_val("t1_total",  32'(total), 32'd81);
    check_val("t1_side",   32'(side),  32'b10);
    check_val("t1_blk",    32'(blk_idx), 32'd0);
    check_val("t1_fd",     32'(frame_done), 32'd0);
    idle(1);
    check_val("t1_pulse",  32'(valid), 32'd0);
    check_val("t1_hold",   32'(diff),  32'h1FFE5);
    #1 res_q.delete();

    // T2: new frame, two back-to-back words
    @(negedge dclk); sof = 1'b1; ready = 1'b0;
    @(negedge dclk); sof = 1'b0;
    check_val("t2_peak_clr", 32'(peak), 32'd0);
    send_word(8'h00, 8'h1B, 8'h00, 8'h36);
    send_word(8'h00, 8'h2D, 8'h00, 8'h48);
    idle(1);
    expect_res("t2_w0", 17'h1FFE5, 17'd81,  2'b10, 4'd0, 1'b0, 16'd27, c0);
    expect_res("t2_w1", 17'h1FFE5, 17'd117, 2'b10, 4'd1, 1'b1, 16'd27, c1);
    check_val("t2_spacing", 32'(c1 - c0), 32'd4);

    // T3: balanced and left-heavier words (frame counter wrapped to 0)
    send_word(8'h00, 8'h30, 8'h00, 8'h2E);
    send_word(8'h00, 8'h40, 8'h00, 8'h30);
    idle(1);
    expect_res("t3_bal",  17'd2,  17'd94,  2'b00, 4'd0, 1'b0, 16'd2,  c0);
    expect_res("t3_left", 17'd16, 17'd112, 2'b01, 4'd1, 1'b1, 16'd16, c1);
    idle(2);

    // T4: stalled partial word is discarded
    vbase = vcount;
    send(8'h00); send(8'h11);
    idle(7);
    idle(1);
    check_val("t4_err_early", 32'(err), 32'd0);
    send(8'h00);
    check_val("t4_err_set", 32'(err), 32'd1);
    send(8'h1B); send(8'h00); send(8'h36);
    idle(1);
    check_val("t4_no_valid", 32'(vcount - vbase), 32'd0);
    expect_res("t4_next", 17'h1FFE5, 17'd81, 2'b10, 4'd0, 1'b0, 16'd27, c0);
    check_val("t4_err_sticky", 32'(err), 32'd1);
    idle(2);

    // T5: sof with ready mid-word restarts capture
    vbase = vcount;
    send(8'h00); send(8'h1B);
    @(negedge dclk); sof = 1'b1; ready = 1'b1; din = 8'h00;
    @(negedge dclk); sof = 1'b0; din = 8'h40;
    check_val("t5_err_clr", 32'(err), 32'd0);
    send(8'h00);
    idle(1);
    idle(2);
    check_val("t5_no_early_valid", 32'(vcount - vbase), 32'd0);
    send(8'h30);
    idle(1);
    expect_res("t5_word", 17'd16, 17'd112, 2'b01, 4'd0, 1'b0, 16'd16, c0);
    idle(2);

    // T6: asynchronous reset during byte 3
    send(8'h00); send(8'h1B); send(8'h00);
    #2 rst_n = 1'b0;
    #1;
    check_val("t6_left",  32'(left),  32'd0);
    check_val("t6_right", 32'(right), 32'd0);
    check_val("t6_diff",  32'(diff),  32'd0);
    check_val("t6_total", 32'(total), 32'd0);
    check_val("t6_side",  32'(side),  32'd0);
    check_val("t6_peak",  32'(peak),  32'd0);
    ready = 1'b0;
    @(negedge dclk); rst_n = 1'b1;
    send_word(8'h00, 8'h2D, 8'h00, 8'h48);
    idle(1);
    expect_res("t6_next", 17'h1FFE5, 17'd117, 2'b10, 4'd0, 1'b0, 16'd27, c0);
    check_val("t6_err", 32'(err), 32'd0);
    idle(3);
    #1;
    check_val("tail_no_extra", 32'(res_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wdec_frame.md
# wdec_frame

Downstream consumer of the block-sum encoder's byte stream, running in the `dclk` domain. It reassembles each 4-byte word into its left and right 16-bit block sums. For every row block it computes the difference, the total and a balance verdict. It also tracks the block position within the frame and detects stalled, incomplete words.

## Interface
- `ROW_BLOCKS`, 2: row blocks per frame; block index wraps after `ROW_BLOCKS-1`.
- `THRESH`, 4: a block with |diff| ≤ THRESH is reported balanced.
- `GAP_MAX`, 8: number of consecutive idle `dclk` cycles inside a partial word that triggers a discard.
- `dclk` input 1: single clock; all logic is on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `sof` input 1: synchronous start-of-frame pulse.
- `ready` input 1: `din` carries a valid byte this cycle.
- `din` input 8: byte stream, MSB-first; order is left[15:8], left[7:0], right[15:8], right[7:0].
- `left` output 16: reassembled left sum.
- `right` output 16: reassembled right sum.
- `diff` output 17: signed left − right, two's complement.
- `total` output 17: unsigned left + right.
- `side` output 2: 00 balanced, 01 left heavier, 10 right heavier; 11 is never driven.
- `blk_idx` output 4: row-block index of the current `valid` result.
- `valid` output 1: one-cycle pulse; all result outputs are new in this cycle.
- `frame_done` output 1: pulses together with `valid` of block `ROW_BLOCKS-1`.
- `err` output 1: sticky flag set when a partial word is discarded.
- `peak` output 16: see Configuration.

## Operation
- Capture FSM states:
  - B0 → B1 → B2 → B3: each transition happens on an edge where `ready`=1.
  - In B0, B1 and B2 the byte goes into the shift register.
  - In B3, the final byte completes the word: `left` and `right` are loaded and the FSM enters CALC.
- CALC lasts exactly one cycle and then returns to B0. In CALC:
  - `diff`, `total` and `side` are registered and `valid` is set.
  - `blk_idx` takes the current block counter value, and the counter then increments.
  - If the counter was `ROW_BLOCKS-1`, it wraps to 0 and `frame_done` is set.
  - A `ready` byte arriving during CALC is accepted as B0 of the next word, so there is no bubble.
- Arithmetic:
  - `diff` = {1'b0,left} − {1'b0,right}.
  - `total` = left + right, 17 bits, so it never overflows.
  - `side` = 00 if |diff| ≤ THRESH; otherwise 01 if diff > 0, else 10.
- Gap handling: in B1–B3, the gap counter counts cycles with `ready`=0 and clears on any accepted byte.
  - When the count reaches GAP_MAX, the FSM returns to B0, the partial bytes are dropped and `err` is set.
  - The block counter does not advance on a discard.
- `sof` has priority over everything:
  - It forces the FSM to B0, clears the block counter, gap counter and `err`, and clears `peak` if peak tracking is compiled in.
  - If `ready`=1 in the same cycle, that byte is taken as B0 of a new word.
  - A word in CALC when `sof` arrives still emits its `valid`, with its `blk_idx` unchanged.
- Reset values:
  - All outputs are 0, including `side`=00.
  - FSM is in B0; block and gap counters are 0.
  - Reset mid-word discards the partial word without setting `err`.

## Timing
- The fourth byte is sampled at edge N. `left` and `right` update at edge N; `valid`, `diff`, `total`, `side`, `blk_idx` and `frame_done` are high for the cycle after edge N+1.
- Back-to-back words can be accepted at one word every 4 cycles, with `valid` every 4 cycles.
- Result registers hold their values until the next `valid`; only `valid` and `frame_done` are pulses.
- The discard occurs at the edge where the gap count reaches GAP_MAX. `err` is visible the following cycle.
- No combinational paths from inputs to outputs.

## Configuration
- `WDEC_PEAK_EN` defined:
  - `peak` holds max |diff| (low 16 bits) over the current frame, updated in the CALC cycle.
  - `peak` is cleared by `sof`, by reset, and at the block-0 `valid` of a new frame, where it is loaded with that block's |diff|.
- `WDEC_PEAK_EN` undefined: `peak` is tied to 0 and no comparator or register is inferred.

## Test plan
- Reset release, then bytes 00,1B,00,36 on consecutive cycles: expect `left`=0x001B, `right`=0x0036, `diff`=−27 (0x1FFE5), `total`=81, `side`=10, `blk_idx`=0, and one `valid` pulse two edges after the last byte.
- Two back-to-back words (00,1B,00,36 then 00,2D,00,48) with ROW_BLOCKS=2: second `valid` reports `blk_idx`=1, `diff`=−27, with `frame_done`=1 on that pulse. With `WDEC_PEAK_EN`, `peak`=27.
- Word 00,30,00,2E (left 48, right 46): `side`=00, because |2| ≤ 4. Word 00,40,00,30: `side`=01, `diff`=+16.
- Send 2 bytes, then hold `ready`=0 for 8 cycles, then send 00,1B,00,36: `err`=1, no `valid` for the partial word, the next word decodes correctly with `blk_idx`=0, and `err` stays 1 until `sof`.
- `sof` together with `ready`=1 mid-word (after byte 2): FSM restarts, and that byte becomes the new left[15:8]. `err` and the block counter are cleared, and `valid` appears only after 3 more bytes.
- Assert `rst_n`=0 asynchronously between dclk edges during byte 3: all outputs drop to 0 immediately, and the next full word decodes with `blk_idx`=0.
